ps2_rx_decoder: RTL and testbench
=================================

PS2_RX_DECODER -- requirements
Module: ps2_rx_decoder

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4, meaning consecutive equal samples needed to accept a KCLK level change.
REQ-002 SHALL have parameter TIMEOUT, default 50000, meaning CLK cycles allowed between filtered KCLK falling edges inside a frame.
REQ-003 SHALL have port CLK  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port RESET  input  1  reset RESET, synchronous, active-high; clock CLK.
REQ-005 SHALL have port KCLK  input  1  asynchronous PS/2 clock line, idle high.
REQ-006 SHALL have port KDAT  input  1  asynchronous PS/2 data line, idle high.
REQ-007 SHALL have port CODE  output  8  last accepted non-prefix scancode.
REQ-008 SHALL have port RELEASE  output  1  CODE was preceded by 0xF0.
REQ-009 SHALL have port EXTENDED  output  1  CODE was preceded by 0xE0.
REQ-010 SHALL have port VALID  output  1  one-cycle pulse when CODE/RELEASE/EXTENDED update.
REQ-011 SHALL have port FRAME_ERR  output  1  one-cycle pulse on a rejected or aborted frame.
REQ-012 SHALL have port BUSY  output  1  high whenever the FSM is not IDLE.

Function
REQ-013 SHALL pass KCLK and KDAT each through a 2-flop synchronizer before any use.
REQ-014 SHALL hold a filtered KCLK level that changes only after FILTER_LEN consecutive synchronized samples differ from it; shorter pulses ignored.
REQ-015 SHALL define a sample event as the cycle in which the filtered KCLK changes 1->0; KDAT (synchronized) is captured in that cycle.
REQ-016 SHALL implement FSM states IDLE, SHIFT, CHECK.
REQ-017 IDLE: sample event with KDAT=0 -> SHIFT, bit count=1; sample event with KDAT=1 ignored, no error.
REQ-018 SHIFT: each sample event stores the bit at index bit count (0 start, 1-8 data LSB first, 9 parity, 10 stop) and increments count; on the event storing bit 10 -> CHECK.
REQ-019 SHIFT: cycle counter clears on each sample event; reaching TIMEOUT -> IDLE, FRAME_ERR pulse, partial frame discarded.
REQ-020 CHECK (one cycle, always -> IDLE): frame good iff XOR of data bits and parity bit =1 (odd parity) and stop bit =1.
REQ-021 Good byte 0xE0: set ext_pending, no VALID.
REQ-022 Good byte 0xF0: set brk_pending, no VALID.
REQ-023 Other good byte: CODE<=byte, RELEASE<=brk_pending, EXTENDED<=ext_pending, VALID pulse, both pendings cleared.
REQ-024 Bad frame: FRAME_ERR pulse, both pendings cleared, CODE/RELEASE/EXTENDED unchanged.
REQ-025 Latency: sample event of stop bit in cycle T -> CHECK in T+1 -> VALID or FRAME_ERR high in T+2 only.
REQ-026 CODE, RELEASE, EXTENDED SHALL hold their values between VALID pulses.
REQ-027 VALID and FRAME_ERR SHALL never be high in the same cycle; sample events during CHECK are ignored.
REQ-028 BUSY SHALL be 1 in SHIFT and CHECK, 0 in IDLE.

Reset
REQ-029 RESET SHALL force: FSM IDLE, bit count 0, timeout counter 0, synchronizer and filter regs 1, pendings 0, CODE 0x00, RELEASE 0, EXTENDED 0, VALID 0, FRAME_ERR 0, BUSY 0.
REQ-030 RESET mid-frame SHALL discard the partial frame without FRAME_ERR; a KCLK held low across reset release is treated as a normal falling edge after FILTER_LEN cycles.

Verification
REQ-031 Frame 0x1C (bits 0,00111000,P=0,1) -> VALID one cycle at T+2, CODE=0x1C, RELEASE=0, EXTENDED=0.
REQ-032 Frames F0,1C -> single VALID after second frame, CODE=0x1C, RELEASE=1, EXTENDED=0; none after F0.
REQ-033 Frames E0,F0,75 -> single VALID, CODE=0x75, RELEASE=1, EXTENDED=1; next frame 0x75 -> RELEASE=0, EXTENDED=0.
REQ-034 Frame 0x16 with parity bit 1 -> FRAME_ERR one cycle, no VALID, CODE unchanged; F0 then bad frame then 0x1C -> RELEASE=0.
REQ-035 Five bits sent then KCLK idle -> FRAME_ERR exactly TIMEOUT cycles after fifth event, BUSY 0; following good 0x1C frame decodes correctly.
REQ-036 KCLK low glitches of FILTER_LEN-1 cycles inside and outside a frame -> no bit captured; RESET asserted mid-frame -> all outputs to reset values, no FRAME_ERR, next frame decodes.

Source files
------------

// File: rtl/ps2_rx_decoder.sv
// PS/2 keyboard receiver: synchronizes and deglitches KCLK, shifts in 11-bit frames,
// and folds 0xE0/0xF0 prefixes into EXTENDED/RELEASE flags on the next scancode.
module ps2_rx_decoder #(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 50000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       KCLK,
    input  logic       KDAT,
    output logic [7:0] CODE,
    output logic       RELEASE,
    output logic       EXTENDED,
    output logic       VALID,
    output logic       FRAME_ERR,
    output logic       BUSY
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    logic          kclk_meta, kclk_sync;
    logic          kdat_meta, kdat_sync;
    logic          kclk_filt;
    logic [FW-1:0] flt_cnt;
    logic          flt_flip;
    logic          sample;

    state_t        state;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [10:1]   frame;
    logic          ext_pending;
    logic          brk_pending;
    logic [7:0]    rx_byte;
    logic          frame_good;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            kclk_meta <= 1'b1;
            kclk_sync <= 1'b1;
            kdat_meta <= 1'b1;
            kdat_sync <= 1'b1;
            kclk_filt <= 1'b1;
            flt_cnt   <= '0;
        end else begin
            kclk_meta <= KCLK;
            kclk_sync <= kclk_meta;
            kdat_meta <= KDAT;
            kdat_sync <= kdat_meta;
            // Count consecutive disagreeing samples; any agreeing sample restarts the run.
            if (kclk_sync != kclk_filt) begin
                if (flt_cnt == FLT_LAST) begin
                    kclk_filt <= kclk_sync;
                    flt_cnt   <= '0;
                end else begin
                    flt_cnt <= flt_cnt + 1'b1;
                end
            end else begin
                flt_cnt <= '0;
            end
        end
    end

    assign flt_flip   = (kclk_sync != kclk_filt) && (flt_cnt == FLT_LAST);
    assign sample     = flt_flip && kclk_filt;
    assign rx_byte    = frame[8:1];
    assign frame_good = (^frame[9:1]) && frame[10];
    assign BUSY       = (state != S_IDLE);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            tmo_cnt     <= '0;
            frame       <= '0;
            ext_pending <= 1'b0;
            brk_pending <= 1'b0;
            CODE        <= 8'h00;
            RELEASE     <= 1'b0;
            EXTENDED    <= 1'b0;
            VALID       <= 1'b0;
            FRAME_ERR   <= 1'b0;
        end else begin
            VALID     <= 1'b0;
            FRAME_ERR <= 1'b0;
            case (state)
                S_IDLE: begin
                    tmo_cnt <= '0;
                    if (sample && !kdat_sync) begin
                        bit_cnt <= 4'd1;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // tmo_cnt holds the number of cycles elapsed since the last sample event.
                    if (sample) begin
                        frame[bit_cnt] <= kdat_sync;
                        bit_cnt        <= bit_cnt + 4'd1;
                        tmo_cnt        <= TW'(1);
                        if (bit_cnt == 4'd10) begin
                            state <= S_CHECK;
                        end
                    end else if (tmo_cnt >= TMO_LAST) begin
                        state     <= S_IDLE;
                        bit_cnt   <= '0;
                        tmo_cnt   <= '0;
                        FRAME_ERR <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    state   <= S_IDLE;
                    bit_cnt <= '0;
                    tmo_cnt <= '0;
                    if (!frame_good) begin
                        FRAME_ERR   <= 1'b1;
                        ext_pending <= 1'b0;
                        brk_pending <= 1'b0;
                    end else if (rx_byte == 8'hE0) begin
                        ext_pending <= 1'b1;
                    end else if (rx_byte == 8'hF0) begin
                        brk_pending <= 1'b1;
                    end else begin
                        CODE        <= rx_byte;
                        RELEASE     <= brk_pending;
                        EXTENDED    <= ext_pending;
                        VALID       <= 1'b1;
                        ext_pending <= 1'b0;
                        brk_pending <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    bit_cnt <= '0;
                    tmo_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_rx_decoder.sv
// Self-checking bench for ps2_rx_decoder: directed prefix/error/timeout/glitch/reset cases
// plus randomized frames scored against a byte-level keyboard protocol model.
module tb_ps2_rx_decoder;

    localparam int FL  = 4;
    localparam int TMO = 300;

    logic       CLK;
    logic       RESET;
    logic       KCLK;
    logic       KDAT;
    logic [7:0] CODE;
    logic       RELEASE;
    logic       EXTENDED;
    logic       VALID;
    logic       FRAME_ERR;
    logic       BUSY;

    ps2_rx_decoder #(.FILTER_LEN(FL), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RESET(RESET), .KCLK(KCLK), .KDAT(KDAT),
        .CODE(CODE), .RELEASE(RELEASE), .EXTENDED(EXTENDED),
        .VALID(VALID), .FRAME_ERR(FRAME_ERR), .BUSY(BUSY)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // scoreboard: expected {RELEASE, EXTENDED, CODE} per VALID pulse
    logic [9:0] exp_q[$];
    int valid_cnt = 0, err_cnt = 0, both_cnt = 0;
    int valid_cyc = 0, err_cyc = 0, fall_cyc = 0;

    always @(negedge CLK) begin
        if (VALID) begin
            valid_cnt++;
            valid_cyc = cyc;
            if (exp_q.size() == 0) check("valid_unexpected", 32'd1, 32'd0);
            else check("valid_data", {22'd0, RELEASE, EXTENDED, CODE}, {22'd0, exp_q.pop_front()});
        end
        if (FRAME_ERR) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (VALID && FRAME_ERR) both_cnt++;
    end

    // reference model: keyboard protocol at the byte level
    logic       m_ext = 1'b0, m_brk = 1'b0;
    logic [7:0] m_code = 8'h00;
    logic       m_rel = 1'b0, m_xt = 1'b0;

    task automatic model_frame(input logic [7:0] d, input bit good, output int ev, output int ee);
        ev = 0;
        ee = 0;
        if (!good) begin
            ee = 1;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (d == 8'hE0) begin
            m_ext = 1'b1;
        end else if (d == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            m_code = d;
            m_rel  = m_brk;
            m_xt   = m_ext;
            m_ext  = 1'b0;
            m_brk  = 1'b0;
            ev     = 1;
            exp_q.push_back({m_rel, m_xt, m_code});
        end
    endtask

    task automatic model_reset();
        m_ext = 1'b0; m_brk = 1'b0; m_code = 8'h00; m_rel = 1'b0; m_xt = 1'b0;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic par;
        par = (~^d) ^ bad_par;
        return {~bad_stop, par, d, 1'b0};
    endfunction

    // drivers
    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch);
        for (int i = 0; i < nbits; i++) begin
            KDAT = bits[i];
            wait_clk(8);
            KCLK = 1'b0;
            fall_cyc = cyc;
            wait_clk(15);
            KCLK = 1'b1;
            if (glitch && i == 4) begin
                wait_clk(6);
                KCLK = 1'b0;
                wait_clk(FL - 1);
                KCLK = 1'b1;
                wait_clk(8);
            end else begin
                wait_clk(7);
            end
        end
        KDAT = 1'b1;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input bit bad_par,
                             input bit bad_stop, input bit glitch);
        int v0, e0, ev, ee;
        v0 = valid_cnt;
        e0 = err_cnt;
        model_frame(d, !(bad_par || bad_stop), ev, ee);
        send_bits(make_frame(d, bad_par, bad_stop), 11, glitch);
        wait_clk(10);
        check({tag, "_valid_cnt"}, valid_cnt - v0, ev);
        check({tag, "_err_cnt"}, err_cnt - e0, ee);
        check({tag, "_code"}, {24'd0, CODE}, {24'd0, m_code});
        check({tag, "_flags"}, {30'd0, RELEASE, EXTENDED}, {30'd0, m_rel, m_xt});
        check({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
        if (valid_cnt - v0 == 1)
            check({tag, "_valid_lat"}, 32'(valid_cyc - fall_cyc >= FL + 2 && valid_cyc - fall_cyc <= FL + 4), 32'd1);
        if (err_cnt - e0 == 1)
            check({tag, "_err_lat"}, 32'(err_cyc - fall_cyc >= FL + 2 && err_cyc - fall_cyc <= FL + 4), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, e0, r;
        logic [7:0] d;
        KCLK  = 1'b1;
        KDAT  = 1'b1;
        RESET = 1'b1;
        wait_clk(5);
        check("rst_code", {24'd0, CODE}, 32'd0);
        check("rst_outs", {28'd0, RELEASE, EXTENDED, VALID, FRAME_ERR}, 32'd0);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        RESET = 1'b0;
        wait_clk(10);

        // directed protocol cases
        run_frame("make_1c", 8'h1C, 0, 0, 0);
        run_frame("brk_f0", 8'hF0, 0, 0, 0);
        run_frame("brk_1c", 8'h1C, 0, 0, 0);
        run_frame("ext_e0", 8'hE0, 0, 0, 0);
        run_frame("ext_f0", 8'hF0, 0, 0, 0);
        run_frame("ext_75", 8'h75, 0, 0, 0);
        run_frame("plain_75", 8'h75, 0, 0, 0);
        run_frame("badpar_16", 8'h16, 1, 0, 0);
        run_frame("clr_f0", 8'hF0, 0, 0, 0);
        run_frame("clr_bad", 8'h2A, 0, 1, 0);
        run_frame("clr_1c", 8'h1C, 0, 0, 0);

        // timeout after five bits
        v0 = valid_cnt;
        e0 = err_cnt;
        send_bits(make_frame(8'h1C, 0, 0), 5, 0);
        wait_clk(TMO + 30);
        check("tmo_err_cnt", err_cnt - e0, 32'd1);
        check("tmo_valid_cnt", valid_cnt - v0, 32'd0);
        check("tmo_err_lat", 32'(err_cyc - fall_cyc >= TMO + FL && err_cyc - fall_cyc <= TMO + FL + 2), 32'd1);
        check("tmo_busy", {31'd0, BUSY}, 32'd0);
        run_frame("after_tmo", 8'h1C, 0, 0, 0);

        // glitches shorter than the filter, inside and outside a frame
        run_frame("glitch_in", 8'h5A, 0, 0, 1);
        e0 = err_cnt;
        KDAT = 1'b0;
        wait_clk(2);
        KCLK = 1'b0;
        wait_clk(FL - 1);
        KCLK = 1'b1;
        wait_clk(4);
        KDAT = 1'b1;
        wait_clk(TMO + 20);
        check("glitch_idle_err", err_cnt - e0, 32'd0);
        check("glitch_idle_busy", {31'd0, BUSY}, 32'd0);
        run_frame("after_glitch", 8'h33, 0, 0, 0);

        // reset in the middle of a frame with a break prefix pending
        run_frame("rst_pre_f0", 8'hF0, 0, 0, 0);
        e0 = err_cnt;
        send_bits(make_frame(8'h42, 0, 0), 6, 0);
        RESET = 1'b1;
        wait_clk(3);
        model_reset();
        check("midrst_code", {24'd0, CODE}, 32'd0);
        check("midrst_flags", {30'd0, RELEASE, EXTENDED}, 32'd0);
        check("midrst_busy", {31'd0, BUSY}, 32'd0);
        RESET = 1'b0;
        wait_clk(TMO + 20);
        check("midrst_err", err_cnt - e0, 32'd0);
        run_frame("after_rst", 8'h1C, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            d = 8'($urandom_range(0, 255));
            case (r)
                0, 1:    run_frame("rnd_e0", 8'hE0, 0, 0, 0);
                2, 3:    run_frame("rnd_f0", 8'hF0, 0, 0, 0);
                4:       run_frame("rnd_badpar", d, 1, 0, 0);
                5:       run_frame("rnd_badstop", d, 0, 1, 0);
                default: run_frame("rnd_byte", d, 0, 0, 0);
            endcase
        end

        check("exp_q_drained", exp_q.size(), 32'd0);
        check("valid_err_overlap", both_cnt, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
